gpr_writeback_scoreboard: RTL and testbench
===========================================

// Module: gpr_writeback_scoreboard
// PURPOSE
//  Decode-stage controller that shares the register file's single write port between the
//  in-order pipeline writeback (W stage) and a multi-cycle mul/div unit (MDU).
//  Keeps a per-register pending bitmap for the MDU's outstanding destination.
//  Stalls decode on RAW/WAW hazards against that destination and issues MDU ops.
//  Arbitrates MDU result commit vs. W-stage writes with a starvation limit.
// PARAMETERS
//  STARVE_LIMIT  4  max cycles a completed MDU result may wait before W stage is stalled
//  CNT_W         3  width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   asynchronous reset, active low
//  D_valid         in   1   decode holds a valid instruction
//  D_flush         in   1   decode instruction is being killed this cycle
//  D_rs1_addr      in   5   source 1 index
//  D_rs2_addr      in   5   source 2 index
//  D_rs1_used      in   1   instruction reads rs1
//  D_rs2_used      in   1   instruction reads rs2
//  D_rd_addr       in   5   destination index
//  D_rd_wen        in   1   instruction writes rd
//  D_is_mdu        in   1   instruction executes on the MDU
//  D_stall         out  1   hold fetch/decode this cycle
//  mdu_start       out  1   one-cycle issue pulse to MDU
//  mdu_done        in   1   MDU result valid (single-cycle pulse)
//  W_gpr_wen       in   1   W stage requests a register write
//  W_rd_addr       in   5   W stage destination
//  W_stall         out  1   W stage write refused; W holds its instruction
//  gpr_wen         out  1   register file write enable
//  gpr_waddr       out  5   register file write address
//  gpr_wsel        out  1   write-data mux select: 0 = W stage, 1 = MDU result
// BEHAVIOUR
//  Reset values: state = IDLE, pending = 0, mdu_rd = 0, starve_cnt = 0, all outputs 0.
//  State machine:
//    IDLE:  no MDU op outstanding.
//    BUSY:  MDU op issued, result not yet returned.
//    WAIT:  MDU result returned but not yet committed.
//  Issue: issue = D_valid & D_is_mdu & ~D_flush & ~D_stall & state==IDLE.
//    On issue: mdu_start = 1 and mdu_rd <= D_rd_addr.
//    If D_rd_wen and D_rd_addr != 0, pending[D_rd_addr] <= 1.
//    Next state is BUSY.
//  D_stall is combinational and is raised when D_valid & ~D_flush and any of:
//    - rs1_used & pending[rs1];
//    - rs2_used & pending[rs2];
//    - rd_wen & pending[rd] (WAW hazard);
//    - D_is_mdu & state != IDLE.
//    Pending bit 0 is never set. Decode has no same-cycle bypass of a commit: the bit clears
//    at the commit edge, so a dependent instruction is released one cycle after commit.
//  Commit, in BUSY with mdu_done:
//    - If ~W_gpr_wen: commit this cycle and go to IDLE.
//    - Otherwise: W stage wins, go to WAIT with starve_cnt = 1.
//  Commit, in WAIT:
//    - Commit when ~W_gpr_wen or starve_cnt == STARVE_LIMIT.
//    - In the second case W_stall = 1 and the W write is suppressed.
//    - Otherwise starve_cnt increments (saturating).
//  On commit:
//    - Drive gpr_wen = 1, gpr_waddr = mdu_rd, gpr_wsel = 1.
//    - pending[mdu_rd] <= 0, starve_cnt <= 0, state <= IDLE.
//    - If mdu_rd == 0, gpr_wen stays 0 but state and counter update identically.
//  No commit:
//    - gpr_wen = W_gpr_wen & ~W_stall, gpr_waddr = W_rd_addr, gpr_wsel = 0.
//    - W_stall = 0 whenever no MDU commit takes the port.
//  mdu_done outside BUSY is ignored; this includes mdu_done after a reset mid-operation.
//  Simultaneous events:
//    - Issue and commit in one cycle are impossible: issue requires IDLE.
//    - D_flush suppresses issue and D_stall for that cycle.
//    - Issued MDU ops are never cancelled.
//  Reset mid-operation: everything returns asynchronously to reset values and the pending
//    bitmap is cleared. A later result from the MDU is dropped.
// TESTING
//  1. MUL x5 issued, MDU done 3 cycles later, W idle:
//     -> mdu_start pulses once; gpr_wen=1, waddr=5, wsel=1 on the done cycle; IDLE next cycle.
//  2. MUL x5, then ADD x6,x5,x1 in decode:
//     -> D_stall=1 until the cycle after commit, then 0; also check rd=x5 WAW stalls the same way.
//  3. mdu_done while W_gpr_wen=1 every cycle, STARVE_LIMIT=4:
//     -> W writes for 4 cycles; on the 5th, W_stall=1 and the MDU commits (wsel=1).
//  4. MUL x0 issued:
//     -> no pending bit set, no stall on x0 readers, done produces gpr_wen=0 and state IDLE.
//  5. Second MDU op in decode while BUSY -> D_stall=1.
//     Same op with D_flush=1 -> D_stall=0 and no mdu_start.
//  6. reset low while in WAIT with pending[7]=1:
//     -> immediate IDLE, pending=0, outputs 0; a later mdu_done causes no write.

Source files
------------

// File: rtl/gpr_writeback_scoreboard_if.sv
// Decode, MDU and W-stage handshake bundle for the writeback scoreboard.
// The slave side is the scoreboard; the master side drives the pipeline inputs.
interface gpr_writeback_scoreboard_if;
  logic       D_valid;
  logic       D_flush;
  logic [4:0] D_rs1_addr;
  logic [4:0] D_rs2_addr;
  logic       D_rs1_used;
  logic       D_rs2_used;
  logic [4:0] D_rd_addr;
  logic       D_rd_wen;
  logic       D_is_mdu;
  logic       D_stall;
  logic       mdu_start;
  logic       mdu_done;
  logic       W_gpr_wen;
  logic [4:0] W_rd_addr;
  logic       W_stall;
  logic       gpr_wen;
  logic [4:0] gpr_waddr;
  logic       gpr_wsel;

  modport master (
    output D_valid, D_flush, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used,
           D_rd_addr, D_rd_wen, D_is_mdu, mdu_done, W_gpr_wen, W_rd_addr,
    input  D_stall, mdu_start, W_stall, gpr_wen, gpr_waddr, gpr_wsel
  );

  modport slave (
    input  D_valid, D_flush, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used,
           D_rd_addr, D_rd_wen, D_is_mdu, mdu_done, W_gpr_wen, W_rd_addr,
    output D_stall, mdu_start, W_stall, gpr_wen, gpr_waddr, gpr_wsel
  );
endinterface

// File: rtl/gpr_writeback_scoreboard.sv
// Shares the GPR write port between W stage and one outstanding MDU op; all outputs are combinational.
// Decode stalls on hazards against the MDU destination; W stage stalls only once an MDU result has starved.
module gpr_writeback_scoreboard #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic                      clk,
  input logic                      reset,
  gpr_writeback_scoreboard_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      pending_q, pending_d;
  logic [4:0]       mdu_rd_q, mdu_rd_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic       hazard;
  logic       d_stall;
  logic       issue;
  logic       commit;
  logic       w_stall;
  logic       wen;
  logic [4:0] waddr;
  logic       wsel;

  // Pending bit 0 is never set, so x0 operands fall out of the hazard check naturally.
  assign hazard = (bus.D_rs1_used & pending_q[bus.D_rs1_addr])
                | (bus.D_rs2_used & pending_q[bus.D_rs2_addr])
                | (bus.D_rd_wen   & pending_q[bus.D_rd_addr])
                | (bus.D_is_mdu   & (state_q != S_IDLE));

  assign d_stall = bus.D_valid & ~bus.D_flush & hazard;
  assign issue   = bus.D_valid & bus.D_is_mdu & ~bus.D_flush & ~d_stall & (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mdu_rd_d  = mdu_rd_q;
    starve_d  = starve_q;
    commit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d  = S_BUSY;
          mdu_rd_d = bus.D_rd_addr;
          if (bus.D_rd_wen && (bus.D_rd_addr != 5'd0)) begin
            pending_d[bus.D_rd_addr] = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (bus.mdu_done) begin
          if (!bus.W_gpr_wen) begin
            commit = 1'b1;
          end else begin
            state_d  = S_WAIT;
            starve_d = CNT_ONE;
          end
        end
      end
      S_WAIT: begin
        if (!bus.W_gpr_wen || (starve_q == LIMIT)) begin
          commit = 1'b1;
        end else if (starve_q != CNT_MAX) begin
          starve_d = starve_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (commit) begin
      pending_d[mdu_rd_q] = 1'b0;
      starve_d            = '0;
      state_d             = S_IDLE;
    end
  end

  // A commit only coexists with a W request when the MDU result has starved.
  assign w_stall = commit & bus.W_gpr_wen;
  assign wen     = commit ? (mdu_rd_q != 5'd0) : (bus.W_gpr_wen & ~w_stall);
  assign waddr   = commit ? mdu_rd_q : bus.W_rd_addr;
  assign wsel    = commit;

  assign bus.D_stall   = d_stall;
  assign bus.mdu_start = issue;
  assign bus.W_stall   = w_stall;
  assign bus.gpr_wen   = wen;
  assign bus.gpr_waddr = waddr;
  assign bus.gpr_wsel  = wsel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      mdu_rd_q  <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mdu_rd_q  <= mdu_rd_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_gpr_writeback_scoreboard.sv
// Directed scenarios followed by random traffic, checked against a behavioural scoreboard model.
module tb_gpr_writeback_scoreboard;
  localparam int LIMIT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gpr_writeback_scoreboard_if bus ();

  gpr_writeback_scoreboard #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: an MDU op is either in flight, or finished and waiting for the port.
  bit m_busy;
  bit m_ready;
  int m_wait;
  int m_dest;
  bit m_pend [32];
  bit e_issue;
  bit e_commit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ready = 0; m_wait = 0; m_dest = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask

  task automatic idle();
    bus.D_valid = 0; bus.D_flush = 0; bus.D_rs1_addr = 0; bus.D_rs2_addr = 0;
    bus.D_rs1_used = 0; bus.D_rs2_used = 0; bus.D_rd_addr = 0; bus.D_rd_wen = 0;
    bus.D_is_mdu = 0; bus.mdu_done = 0; bus.W_gpr_wen = 0; bus.W_rd_addr = 0;
  endtask

  task automatic dec(input bit fl, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wen, input bit mdu);
    bus.D_valid = 1; bus.D_flush = fl;
    bus.D_rs1_addr = 5'(rs1); bus.D_rs1_used = u1;
    bus.D_rs2_addr = 5'(rs2); bus.D_rs2_used = u2;
    bus.D_rd_addr = 5'(rd); bus.D_rd_wen = wen; bus.D_is_mdu = mdu;
  endtask

  // Compare all outputs against the model for the current inputs.
  task automatic settle(input string tag);
    bit s, wst, wen, ws;
    int wa;
    #3;
    s = bus.D_valid && !bus.D_flush &&
        ((bus.D_rs1_used && m_pend[bus.D_rs1_addr]) ||
         (bus.D_rs2_used && m_pend[bus.D_rs2_addr]) ||
         (bus.D_rd_wen   && m_pend[bus.D_rd_addr])  ||
         (bus.D_is_mdu   && (m_busy || m_ready)));
    e_issue  = bus.D_valid && bus.D_is_mdu && !bus.D_flush && !s && !m_busy && !m_ready;
    e_commit = (m_busy && bus.mdu_done && !bus.W_gpr_wen) ||
               (m_ready && (!bus.W_gpr_wen || m_wait == LIMIT));
    wst = e_commit && bus.W_gpr_wen;
    if (e_commit) begin
      wen = (m_dest != 0); wa = m_dest; ws = 1;
    end else begin
      wen = bus.W_gpr_wen; wa = int'(bus.W_rd_addr); ws = 0;
    end
    chk({tag, "_D_stall"},   32'(bus.D_stall),   32'(s));
    chk({tag, "_mdu_start"}, 32'(bus.mdu_start), 32'(e_issue));
    chk({tag, "_W_stall"},   32'(bus.W_stall),   32'(wst));
    chk({tag, "_gpr_wen"},   32'(bus.gpr_wen),   32'(wen));
    chk({tag, "_gpr_waddr"}, 32'(bus.gpr_waddr), 32'(wa));
    chk({tag, "_gpr_wsel"},  32'(bus.gpr_wsel),  32'(ws));
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_commit) begin
      m_pend[m_dest] = 0; m_busy = 0; m_ready = 0; m_wait = 0;
    end else if (m_busy && bus.mdu_done && bus.W_gpr_wen) begin
      m_busy = 0; m_ready = 1; m_wait = 1;
    end else if (m_ready && m_wait < LIMIT) begin
      m_wait++;
    end
    if (e_issue) begin
      m_busy = 1;
      m_dest = int'(bus.D_rd_addr);
      if (bus.D_rd_wen && bus.D_rd_addr != 0) m_pend[bus.D_rd_addr] = 1;
    end
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_D_stall"},   32'(bus.D_stall),   0);
    chk({tag, "_mdu_start"}, 32'(bus.mdu_start), 0);
    chk({tag, "_W_stall"},   32'(bus.W_stall),   0);
    chk({tag, "_gpr_wen"},   32'(bus.gpr_wen),   0);
    chk({tag, "_gpr_waddr"}, 32'(bus.gpr_waddr), 0);
    chk({tag, "_gpr_wsel"},  32'(bus.gpr_wsel),  0);
  endtask

  task automatic issue_mul(input string tag, input int rd);
    idle(); dec(0, 0, 0, 0, 0, rd, 1, 1);
    settle(tag);
    chk({tag, "_start"}, 32'(bus.mdu_start), 1);
    tick();
  endtask

  initial begin
    idle();
    model_reset();
    reset = 0;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1;

    // 1: MUL x5, done three cycles later with W idle
    issue_mul("t1_issue", 5);
    idle(); settle("t1_busy0"); tick();
    settle("t1_busy1"); tick();
    bus.mdu_done = 1;
    settle("t1_done");
    chk("t1_wen", 32'(bus.gpr_wen), 1);
    chk("t1_waddr", 32'(bus.gpr_waddr), 5);
    chk("t1_wsel", 32'(bus.gpr_wsel), 1);
    tick();
    idle(); settle("t1_after");
    chk("t1_after_start", 32'(bus.mdu_start), 0);
    tick();

    // 2: RAW on x5 released one cycle after commit, then the same for WAW
    issue_mul("t2_issue", 5);
    idle(); dec(0, 5, 1, 1, 1, 6, 1, 0);
    settle("t2_raw0"); chk("t2_raw0_stall", 32'(bus.D_stall), 1); tick();
    settle("t2_raw1"); tick();
    bus.mdu_done = 1;
    settle("t2_rawdone"); chk("t2_rawdone_stall", 32'(bus.D_stall), 1); tick();
    bus.mdu_done = 0;
    settle("t2_rawrel"); chk("t2_rawrel_stall", 32'(bus.D_stall), 0); tick();
    issue_mul("t2_issue2", 5);
    idle(); dec(0, 0, 0, 0, 0, 5, 1, 0);
    settle("t2_waw0"); chk("t2_waw0_stall", 32'(bus.D_stall), 1); tick();
    bus.mdu_done = 1;
    settle("t2_wawdone"); chk("t2_wawdone_stall", 32'(bus.D_stall), 1); tick();
    bus.mdu_done = 0;
    settle("t2_wawrel"); chk("t2_wawrel_stall", 32'(bus.D_stall), 0); tick();

    // 3: W writes every cycle; MDU result forces its way in on the fifth
    issue_mul("t3_issue", 9);
    idle(); bus.W_gpr_wen = 1; bus.W_rd_addr = 3; bus.mdu_done = 1;
    for (int i = 0; i < 4; i++) begin
      settle("t3_wwin");
      chk("t3_wwin_wsel", 32'(bus.gpr_wsel), 0);
      chk("t3_wwin_waddr", 32'(bus.gpr_waddr), 3);
      tick();
      bus.mdu_done = 0;
    end
    settle("t3_starve");
    chk("t3_starve_wstall", 32'(bus.W_stall), 1);
    chk("t3_starve_wsel", 32'(bus.gpr_wsel), 1);
    chk("t3_starve_waddr", 32'(bus.gpr_waddr), 9);
    tick();
    settle("t3_after"); chk("t3_after_wstall", 32'(bus.W_stall), 0); tick();

    // 4: MUL x0 sets no pending bit and commits without a write
    issue_mul("t4_issue", 0);
    idle(); dec(0, 0, 1, 0, 1, 0, 1, 0);
    settle("t4_x0rd"); chk("t4_x0rd_stall", 32'(bus.D_stall), 0); tick();
    idle(); bus.mdu_done = 1;
    settle("t4_done"); chk("t4_done_wen", 32'(bus.gpr_wen), 0); tick();
    issue_mul("t4_idle", 11);

    // 5: second MDU op while busy stalls; flushed copy neither stalls nor issues
    idle(); dec(0, 0, 0, 0, 0, 4, 1, 1);
    settle("t5_busy"); chk("t5_busy_stall", 32'(bus.D_stall), 1); tick();
    bus.D_flush = 1;
    settle("t5_flush");
    chk("t5_flush_stall", 32'(bus.D_stall), 0);
    chk("t5_flush_start", 32'(bus.mdu_start), 0);
    tick();
    idle(); bus.mdu_done = 1; settle("t5_done"); tick();

    // 6: reset while the x7 result waits for the port
    issue_mul("t6_issue", 7);
    idle(); bus.W_gpr_wen = 1; bus.W_rd_addr = 2; bus.mdu_done = 1;
    settle("t6_towait"); tick();
    bus.mdu_done = 0;
    settle("t6_wait"); tick();
    idle();
    #2 reset = 0;
    model_reset();
    #1;
    chk_all_zero("t6_rst");
    @(posedge clk); #1;
    reset = 1;
    dec(0, 7, 1, 0, 0, 8, 1, 0);
    settle("t6_rd7"); chk("t6_rd7_stall", 32'(bus.D_stall), 0); tick();
    idle(); bus.mdu_done = 1;
    settle("t6_late"); chk("t6_late_wen", 32'(bus.gpr_wen), 0); tick();

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      bus.D_valid    = ($urandom % 4) != 0;
      bus.D_flush    = ($urandom % 8) == 0;
      bus.D_rs1_addr = 5'($urandom % 8);
      bus.D_rs2_addr = 5'($urandom % 8);
      bus.D_rs1_used = 1'($urandom % 2);
      bus.D_rs2_used = 1'($urandom % 2);
      bus.D_rd_addr  = 5'($urandom % 8);
      bus.D_rd_wen   = 1'($urandom % 2);
      bus.D_is_mdu   = ($urandom % 3) == 0;
      bus.mdu_done   = ($urandom % 4) == 0;
      bus.W_gpr_wen  = ($urandom % 3) != 0;
      bus.W_rd_addr  = 5'($urandom % 32);
      settle("rnd");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
